// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd1,
    ADJUST = 2'd2
  } sw_state_e;

  localparam int unsigned ONE_HZ_DIV_DEF = 100_000_000;
  localparam int unsigned TWO_HZ_DIV_DEF = 50_000_000;
  localparam int unsigned BLINK_DIV_DEF  = 25_000_000;
  localparam int unsigned SCAN_DIV_DEF   = 200_000;
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 2;

  // Counter width for a divide-by-div counter; never narrower than one bit.
  function automatic int cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-side inputs and datapath-side control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic                  sw_adj;
  logic                  sw_sel;
  logic                  btn_pause;
  logic                  btn_reset;
  logic                  inc_sec;
  logic                  inc_min;
  logic                  carry_en;
  logic                  clr;
  logic                  blank_min;
  logic                  blank_sec;
  logic [DIGIT_W-1:0]    digit_idx;
  logic [NUM_DIGITS-1:0] an;
  logic                  paused;

  // Controller side: consumes board inputs, drives counter/display controls.
  modport master (
    input  sw_adj, sw_sel, btn_pause, btn_reset,
    output inc_sec, inc_min, carry_en, clr, blank_min, blank_sec, digit_idx, an, paused
  );

  // Board/datapath side.
  modport slave (
    output sw_adj, sw_sel, btn_pause, btn_reset,
    input  inc_sec, inc_min, carry_en, clr, blank_min, blank_sec, digit_idx, an, paused
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int              CNT_W    = cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; accept on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, stability counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: input conditioning, RUN/PAUSE/ADJUST FSM, count strobes, blink and scan.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned ONE_HZ_DIV = ONE_HZ_DIV_DEF,
  parameter int unsigned TWO_HZ_DIV = TWO_HZ_DIV_DEF,
  parameter int unsigned BLINK_DIV  = BLINK_DIV_DEF,
  parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic              clk,
  input logic              rst_n,
  stopwatch_ctrl_if.master bus
);

  localparam int D1_W = cnt_w(ONE_HZ_DIV);
  localparam int D2_W = cnt_w(TWO_HZ_DIV);
  localparam int BL_W = cnt_w(BLINK_DIV);
  localparam int SC_W = cnt_w(SCAN_DIV);
  localparam logic [D1_W-1:0] D1_LAST = D1_W'(ONE_HZ_DIV - 1);
  localparam logic [D2_W-1:0] D2_LAST = D2_W'(TWO_HZ_DIV - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  logic               adj_s1_q, adj_s2_q, sel_s1_q, sel_s2_q;
  logic               pause_p, reset_p;
  sw_state_e          state_q, state_d;
  logic               paused_q, paused_d, clr_q, clr_d;
  logic               inc_sec_q, inc_sec_d, inc_min_q, inc_min_d;
  logic [D1_W-1:0]    div1_q, div1_d;
  logic [D2_W-1:0]    div2_q, div2_d;
  logic [BL_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [SC_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_pause), .pulse_o(pause_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_reset), .pulse_o(reset_p)
  );

  // Two-stage synchronisers for the ADJ and SEL switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_s1_q <= 1'b0;
      adj_s2_q <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
    end else begin
      adj_s1_q <= bus.sw_adj;
      adj_s2_q <= adj_s1_q;
      sel_s1_q <= bus.sw_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  // Mode selection: adjust switch first, then the pause flag.
  always_comb begin
    state_d = RUN;
    if (adj_s2_q) begin
      state_d = ADJUST;
    end else if (paused_q) begin
      state_d = PAUSE;
    end
  end

  // Pause flag, clear strobe, the two count dividers and the inc strobes.
  always_comb begin
    paused_d  = paused_q;
    clr_d     = reset_p;
    div1_d    = div1_q;
    div2_d    = '0;
    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
    if (reset_p) begin
      paused_d = 1'b0;
    end else if (pause_p) begin
      paused_d = ~paused_q;
    end
    case (state_q)
      RUN: begin
        div1_d    = (div1_q == D1_LAST) ? '0 : div1_q + 1'b1;
        inc_sec_d = (div1_q == D1_LAST);
      end
      ADJUST: begin
        div1_d = '0;
        div2_d = (div2_q == D2_LAST) ? '0 : div2_q + 1'b1;
        if (div2_q == D2_LAST) begin
          inc_sec_d = sel_s2_q;
          inc_min_d = ~sel_s2_q;
        end
      end
      default: ;
    endcase
    // A reset press restarts the count and must never overlap a count strobe with clr.
    if (reset_p) begin
      div1_d    = '0;
      div2_d    = '0;
      inc_sec_d = 1'b0;
      inc_min_d = 1'b0;
    end
  end

  // Free-running blink and anode-scan timebases.
  always_comb begin
    blink_cnt_d = (blink_cnt_q == BL_LAST) ? '0 : blink_cnt_q + 1'b1;
    blink_d     = (blink_cnt_q == BL_LAST) ? ~blink_q : blink_q;
    scan_cnt_d  = (scan_cnt_q == SC_LAST) ? '0 : scan_cnt_q + 1'b1;
    digit_d     = (scan_cnt_q == SC_LAST) ? digit_q + 1'b1 : digit_q;
  end

  // State, control and timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      paused_q    <= 1'b0;
      clr_q       <= 1'b0;
      inc_sec_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      div1_q      <= '0;
      div2_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      scan_cnt_q  <= '0;
      digit_q     <= '0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      clr_q       <= clr_d;
      inc_sec_q   <= inc_sec_d;
      inc_min_q   <= inc_min_d;
      div1_q      <= div1_d;
      div2_q      <= div2_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
    end
  end

  assign bus.inc_sec   = inc_sec_q;
  assign bus.inc_min   = inc_min_q;
  assign bus.clr       = clr_q;
  assign bus.paused    = paused_q;
  assign bus.carry_en  = (state_q != ADJUST);
  assign bus.blank_min = (state_q == ADJUST) & ~sel_s2_q & blink_q;
  assign bus.blank_sec = (state_q == ADJUST) & sel_s2_q & blink_q;
  assign bus.digit_idx = digit_q;
  assign bus.an        = ~(NUM_DIGITS'(1) << digit_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with small divider values.
module tb_stopwatch_ctrl;

  localparam int unsigned ONE   = 10;
  localparam int unsigned TWO   = 5;
  localparam int unsigned BLINK = 3;
  localparam int unsigned SCAN  = 4;
  localparam int unsigned DEB   = 4;

  localparam int K_CLR = 1;
  localparam int K_SEC = 2;
  localparam int K_MIN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int k0       = 0;
  longint exp_q[$];

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(
    .ONE_HZ_DIV(ONE), .TWO_HZ_DIV(TWO), .BLINK_DIV(BLINK), .SCAN_DIV(SCAN), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event code = kind * 1e6 + cycle number at which the strobe is high.
  task automatic expect_ev(input int kind, input int at);
    exp_q.push_back(longint'(kind) * 1000000 + longint'(at));
  endtask

  task automatic sb_pop(input int kind);
    longint got;
    got = longint'(kind) * 1000000 + longint'(cyc);
    if (exp_q.size() == 0) chk("sb_unexpected", got, 0);
    else                   chk("sb_event", got, exp_q.pop_front());
  endtask

  function automatic logic [3:0] exp_an(input int rel);
    int d;
    d = (rel / int'(SCAN)) % 4;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic exp_blink(input int rel);
    return ((rel / int'(BLINK)) % 2) == 1;
  endfunction

  function automatic logic pause_pat(input int i);
    if (i < 10) return ((i / 2) % 2) == 0;
    if (i < 30) return 1'b1;
    if (i < 40) return 1'b0;
    if (i < 50) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe monitor and scan/anode check, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.clr)     sb_pop(K_CLR);
      if (bus.inc_sec) sb_pop(K_SEC);
      if (bus.inc_min) sb_pop(K_MIN);
      chk("an", bus.an, exp_an(cyc - k0));
      chk("digit_idx", bus.digit_idx, exp_an(cyc - k0) == 4'b1110 ? 0 :
                                      exp_an(cyc - k0) == 4'b1101 ? 1 :
                                      exp_an(cyc - k0) == 4'b1011 ? 2 : 3);
    end
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_inc_sec"},   bus.inc_sec, 0);
    chk({pfx, "_inc_min"},   bus.inc_min, 0);
    chk({pfx, "_clr"},       bus.clr, 0);
    chk({pfx, "_paused"},    bus.paused, 0);
    chk({pfx, "_carry_en"},  bus.carry_en, 1);
    chk({pfx, "_blank_min"}, bus.blank_min, 0);
    chk({pfx, "_blank_sec"}, bus.blank_sec, 0);
    chk({pfx, "_digit_idx"}, bus.digit_idx, 0);
    chk({pfx, "_an"},        bus.an, 4'b1110);
  endtask

  initial begin
    int j, r, a0, b0, d0;
    bus.sw_adj    = 1'b0;
    bus.sw_sel    = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_reset = 1'b0;
    step(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    k0    = cyc;

    // 1: free run, one inc_sec every 10 cycles
    for (int n = 1; n <= 10; n++) expect_ev(K_SEC, k0 + 10 * n);
    step(100);
    chk("s1_pending", exp_q.size(), 1);

    // 2: bouncy pause press, hold, release, second press resumes from residual
    j = cyc;
    expect_ev(K_SEC, j + 10);
    expect_ev(K_SEC, j + 52);
    for (int i = 0; i < 60; i++) begin
      bus.btn_pause = pause_pat(i);
      if (i == 14) chk("s2_paused_before", bus.paused, 0);
      if (i == 15) chk("s2_paused_set", bus.paused, 1);
      if (i == 30) chk("s2_paused_held", bus.paused, 1);
      if (i == 46) chk("s2_paused_still", bus.paused, 1);
      if (i == 47) chk("s2_paused_clear", bus.paused, 0);
      step(1);
    end

    // 3: reset press, then pause and reset together
    r = cyc;
    expect_ev(K_SEC, r + 2);
    expect_ev(K_CLR, r + 12);
    expect_ev(K_SEC, r + 22);
    expect_ev(K_SEC, r + 32);
    expect_ev(K_CLR, r + 37);
    expect_ev(K_SEC, r + 47);
    for (int i = 0; i < 50; i++) begin
      bus.btn_reset = ((i >= 5) && (i < 15)) || ((i >= 30) && (i < 40));
      bus.btn_pause = (i >= 30) && (i < 40);
      if (i == 13) chk("s3_paused_after_clr", bus.paused, 0);
      if ((i >= 37) && (i <= 40)) chk("s3_paused_both", bus.paused, 0);
      step(1);
    end

    // 4: adjust minutes
    a0 = cyc;
    for (int n = 0; n < 6; n++) expect_ev(K_MIN, a0 + 8 + 5 * n);
    bus.sw_adj = 1'b1;
    bus.sw_sel = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == 2) chk("s4_carry_before", bus.carry_en, 1);
      if (i >= 3) begin
        chk("s4_carry_en", bus.carry_en, 0);
        chk("s4_blank_min", bus.blank_min, exp_blink(cyc - k0));
        chk("s4_blank_sec", bus.blank_sec, 0);
      end
      step(1);
    end

    // 5: adjust seconds, then leave adjust with paused=0
    b0 = cyc;
    expect_ev(K_SEC, b0 + 3);
    expect_ev(K_SEC, b0 + 8);
    expect_ev(K_SEC, b0 + 13);
    expect_ev(K_SEC, b0 + 18);
    expect_ev(K_SEC, b0 + 32);
    expect_ev(K_SEC, b0 + 42);
    bus.sw_sel = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i == 19) bus.sw_adj = 1'b0;
      if ((i >= 2) && (i <= 21)) begin
        chk("s5_blank_sec", bus.blank_sec, exp_blink(cyc - k0));
        chk("s5_blank_min", bus.blank_min, 0);
      end
      if (i == 21) chk("s5_carry_adj", bus.carry_en, 0);
      if (i >= 22) begin
        chk("s5_carry_run", bus.carry_en, 1);
        chk("s5_blank_sec_run", bus.blank_sec, 0);
      end
      step(1);
    end

    // 6: asynchronous reset in the middle of adjust, landing on an inc_min strobe
    d0 = cyc;
    expect_ev(K_MIN, d0 + 8);
    bus.sw_sel = 1'b0;
    bus.sw_adj = 1'b1;
    step(13);
    #1;
    rst_n      = 1'b0;
    bus.sw_adj = 1'b0;
    #1;
    chk_reset_vals("arst");
    step(1);
    #1;
    rst_n = 1'b1;
    k0    = cyc;
    expect_ev(K_SEC, k0 + 10);
    expect_ev(K_SEC, k0 + 20);
    for (int i = 0; i < 25; i++) begin
      if ((i == 1) || (i == 5) || (i == 15)) chk("s6_carry_run", bus.carry_en, 1);
      step(1);
    end
    chk("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
